pipelined_reducer: RTL
======================

PIPELINED_REDUCER -- requirements
Module: pipelined_reducer

Interface
REQ-001 SHALL have parameter LEVELS, default 5, number of radix-4 tree levels; input width per channel is 4**LEVELS, and LEVELS SHALL be at least 1.
REQ-002 SHALL have parameter CHANNELS, default 1, number of independent reduction lanes; CHANNELS SHALL be at least 1.
REQ-003 SHALL have parameter CNT_W, default 16, width of the ones counter.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  input vector and op are valid this cycle.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 in_op  in  2  reduction operator (reducer_pkg::op_t), sampled with data.
REQ-009 in_vector  in  CHANNELS*4**LEVELS  channel c occupies bits [c*4**LEVELS +: 4**LEVELS].
REQ-010 out_valid  out  1  out_bits holds a result.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 out_bits  out  CHANNELS  bit c is the reduction of channel c.
REQ-013 cnt_clear  in  1  synchronous clear of ones_count.
REQ-014 ones_count  out  CNT_W  saturating count of accepted results whose bit 0 is 1.

Function
REQ-015 Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-016 Pipeline enable en = out_ready || !out_valid; in_ready SHALL equal en; every stage SHALL hold when en=0.
REQ-017 Depth: one input register stage plus LEVELS reduction stages; latency SHALL be exactly LEVELS+1 cycles from transfer to out_valid with out_ready held at 1.
REQ-018 Each stage SHALL carry a valid bit and the op; bubbles SHALL propagate and SHALL NOT be collapsed.
REQ-019 Each reduction stage SHALL reduce every aligned 4-bit group to 1 bit with the op carried by that stage: OP_XOR gives parity, OP_AND gives all-ones, OP_OR gives any-one; OP_RSVD (3) SHALL behave as OP_XOR.
REQ-020 Different ops SHALL coexist in flight; each result SHALL use the op sampled with its own input.
REQ-021 Throughput: one result per cycle when in_valid=1 and out_ready=1 continuously.
REQ-022 While out_valid=1 and out_ready=0, out_bits SHALL stay stable.
REQ-023 ones_count SHALL increment by 1 on each output transfer where out_bits[0]=1, and SHALL saturate at 2**CNT_W-1.
REQ-024 cnt_clear=1 SHALL set ones_count to 0 next cycle and SHALL take priority over a simultaneous increment.
REQ-025 Data bits of stages holding no valid entry are don't-care, but out_bits SHALL read 0 whenever out_valid=0.

Reset
REQ-026 reset_n=0 SHALL immediately clear all stage valid bits, out_valid, out_bits and ones_count to 0.
REQ-027 Reset mid-operation SHALL discard all in-flight entries; no result from before reset SHALL appear afterwards.
REQ-028 in_ready SHALL be 1 in the first cycle after reset_n deasserts.

Structure
REQ-029 Package reducer_pkg SHALL define op_t (OP_XOR=0, OP_AND=1, OP_OR=2, OP_RSVD=3) and the function reducing 4 bits by an op_t.
REQ-030 Sub-module reducer_stage (parameters IN_W and CHANNELS) SHALL implement one registered 4:1 level with valid/op pass-through and enable; the top SHALL instantiate it LEVELS times through a generate loop.

Verification (LEVELS=2, CHANNELS=2, CNT_W=4)
REQ-031 in_vector=32'h0001_0003, OP_XOR, out_ready=1 -> out_valid exactly 3 cycles later, out_bits=2'b10.
REQ-032 Back-to-back inputs 32'hFFFF_FFFF with OP_AND, then OP_OR with 32'h0000_0100, then OP_XOR with 32'h0000_0000, out_ready=1 -> out_bits 2'b11, 2'b01, 2'b00 in three consecutive cycles.
REQ-033 Hold out_ready=0 for 5 cycles while streaming 6 inputs -> in_ready falls to 0 once the pipe is full, no input lost or duplicated, all results delivered in order after release.
REQ-034 17 accepted results with out_bits[0]=1 -> ones_count=15 (saturated); cnt_clear coinciding with an increment -> ones_count=0.
REQ-035 Assert reset_n=0 with 2 entries in flight -> out_valid=0 immediately; after release, only post-reset inputs produce outputs.
REQ-036 OP_RSVD with 32'h0000_0007 -> out_bits=2'b01, identical to the OP_XOR result.

Source files
------------

// File: rtl/reducer_pkg.sv
// reducer_pkg
//   Shared types and helpers for the pipelined radix-4 reducer.
//   op_t     : reduction operator carried alongside every data word.
//   reduce4  : collapses one aligned 4-bit group to a single bit.
package reducer_pkg;

    typedef enum logic [1:0] {
        OP_XOR  = 2'd0,
        OP_AND  = 2'd1,
        OP_OR   = 2'd2,
        OP_RSVD = 2'd3
    } op_t;

    // The reserved code falls into the parity branch.
    function automatic logic reduce4(input logic [3:0] bits, input op_t op);
        case (op)
            OP_AND:  return &bits;
            OP_OR:   return |bits;
            default: return ^bits;
        endcase
    endfunction

endpackage

// File: rtl/reducer_stage.sv
// reducer_stage
//   One registered 4:1 reduction level for CHANNELS lanes of IN_W bits each.
//   Ports:
//     clock, reset_n       : clock, asynchronous active-low reset (valid only)
//     en                   : stage advance; everything holds when low
//     vld_p0, op_p0        : incoming valid bit and operator
//     data_p0              : CHANNELS*IN_W incoming bits, lane c at [c*IN_W +: IN_W]
//     vld_p1, op_p1        : registered valid bit and operator
//     data_p1              : CHANNELS*IN_W/4 reduced bits, lane c at [c*IN_W/4 +: IN_W/4]
module reducer_stage
    import reducer_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int CHANNELS = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           en,
    input  logic                           vld_p0,
    input  op_t                            op_p0,
    input  logic [CHANNELS*IN_W-1:0]       data_p0,
    output logic                           vld_p1,
    output op_t                            op_p1,
    output logic [CHANNELS*(IN_W/4)-1:0]   data_p1
);

    localparam int GROUPS = CHANNELS * (IN_W / 4);

    // Lanes are contiguous and IN_W is a multiple of 4, so flat group g of the
    // whole vector lands exactly on output bit g of the reduced vector.
    logic [GROUPS-1:0] red;

    always_comb begin
        red = '0;
        for (int g = 0; g < GROUPS; g++) begin
            red[g] = reduce4(data_p0[g*4 +: 4], op_p0);
        end
    end

    // ---- stage boundary p0 -> p1 ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clock) begin
        if (en) begin
            op_p1   <= op_p0;
            data_p1 <= red;
        end
    end

endmodule

// File: rtl/pipelined_reducer.sv
// pipelined_reducer
//   Per-lane reduction (parity / all-ones / any-one) of 4**LEVELS-bit lanes
//   through one input register and LEVELS radix-4 stages, with a saturating
//   count of delivered results whose lane-0 bit is 1.
//   Ports:
//     clock, reset_n        : clock, asynchronous active-low reset
//     in_valid, in_ready    : input handshake
//     in_op, in_vector      : operator and CHANNELS lanes of 4**LEVELS bits
//     out_valid, out_ready  : output handshake
//     out_bits              : one reduced bit per lane, zero when not valid
//     cnt_clear, ones_count : synchronous clear / saturating ones counter
module pipelined_reducer
    import reducer_pkg::*;
#(
    parameter int LEVELS   = 5,
    parameter int CHANNELS = 1,
    parameter int CNT_W    = 16
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  op_t                                in_op,
    input  logic [CHANNELS*(4**LEVELS)-1:0]    in_vector,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CHANNELS-1:0]                out_bits,
    input  logic                               cnt_clear,
    output logic [CNT_W-1:0]                   ones_count
);

    localparam int VEC_W = CHANNELS * (4**LEVELS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The whole pipe stalls as one unit; bubbles keep their slot.
    logic en;
    assign en       = out_ready || !out_valid;
    assign in_ready = en;

    logic             vld_p0;
    op_t              op_p0;
    logic [VEC_W-1:0] data_p0;

    // ---- stage boundary input -> p0 ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
        end else if (en) begin
            vld_p0 <= in_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (en) begin
            op_p0   <= in_op;
            data_p0 <= in_vector;
        end
    end

    // ---- reduction stages p0 -> p1 ... p(LEVELS) ----
    for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
        localparam int IN_W = 4**(LEVELS - i);

        logic                          vld_d;
        op_t                           op_d;
        logic [CHANNELS*IN_W-1:0]      data_d;
        logic                          vld_q;
        op_t                           op_q;
        logic [CHANNELS*(IN_W/4)-1:0]  data_q;

        if (i == 0) begin : g_first
            assign vld_d  = vld_p0;
            assign op_d   = op_p0;
            assign data_d = data_p0;
        end else begin : g_next
            assign vld_d  = g_lvl[i-1].vld_q;
            assign op_d   = g_lvl[i-1].op_q;
            assign data_d = g_lvl[i-1].data_q;
        end

        reducer_stage #(
            .IN_W     (IN_W),
            .CHANNELS (CHANNELS)
        ) u_stage (
            .clock   (clock),
            .reset_n (reset_n),
            .en      (en),
            .vld_p0  (vld_d),
            .op_p0   (op_d),
            .data_p0 (data_d),
            .vld_p1  (vld_q),
            .op_p1   (op_q),
            .data_p1 (data_q)
        );
    end

    // Data registers are never reset, so the output is masked by valid.
    assign out_valid = g_lvl[LEVELS-1].vld_q;
    assign out_bits  = g_lvl[LEVELS-1].data_q & {CHANNELS{out_valid}};

    // ---- ones counter ----
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (cnt_clear) begin
            count_q <= '0;
        end else if (out_valid && out_ready && out_bits[0]) begin
            count_q <= sat_inc(count_q);
        end
    end

    assign ones_count = count_q;

endmodule
